// File: rtl/lfsr8_digit_src.sv
// 8-bit maximal-length LFSR stepped by a debounced button or an auto timer; feeds two hex digit decoders.
// Optional wrap detection (wrap_pulse output and start register) is enabled by defining LFSR_WRAP_DETECT_EN.
module lfsr8_digit_src #(
  parameter logic [7:0] SEED        = 8'h01,
  parameter int         DEB_CYCLES  = 20000,
  parameter int         AUTO_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       auto_en,
  output logic [7:0] q,
  output logic [3:0] nib_lo,
  output logic [3:0] nib_hi,
  output logic       step_pulse
`ifdef LFSR_WRAP_DETECT_EN
  ,
  output logic       wrap_pulse
`endif
);

  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } deb_state_e;

  // Button synchronizer
  logic sync1_q, sync2_q;
  logic sync1_d, sync2_d;
  logic btn_s;

  always_comb begin
    sync1_d = btn_step;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign btn_s = sync2_q;

  // Debounce FSM: a level change is accepted only after DEB_CYCLES stable samples
  deb_state_e       deb_state_q, deb_state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             manual_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_state_q <= IDLE;
      deb_cnt_q   <= '0;
    end else begin
      deb_state_q <= deb_state_d;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  always_comb begin
    deb_state_d = deb_state_q;
    deb_cnt_d   = deb_cnt_q;
    manual_step = 1'b0;
    case (deb_state_q)
      IDLE: begin
        if (btn_s) begin
          deb_state_d = WAIT_PRESS;
          deb_cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s) begin
          deb_state_d = IDLE;
          deb_cnt_d   = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_state_d = PRESSED;
          deb_cnt_d   = '0;
          manual_step = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          deb_state_d = WAIT_RELEASE;
          deb_cnt_d   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s) begin
          deb_state_d = PRESSED;
          deb_cnt_d   = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_state_d = IDLE;
          deb_cnt_d   = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        deb_state_d = IDLE;
        deb_cnt_d   = '0;
      end
    endcase
  end

  // Auto-step timer; a load restarts the period so the next auto step is a full period away
  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
  logic              auto_step;

  always_comb begin
    auto_cnt_d = auto_cnt_q;
    auto_step  = 1'b0;
    if (load || !auto_en) begin
      auto_cnt_d = '0;
    end else if (auto_cnt_q == AUTO_LAST) begin
      auto_cnt_d = '0;
      auto_step  = 1'b1;
    end else begin
      auto_cnt_d = auto_cnt_q + AUTO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt_q <= '0;
    end else begin
      auto_cnt_q <= auto_cnt_d;
    end
  end

  // LFSR state register; load wins over any step request in the same cycle
  logic [7:0] q_q, q_d;
  logic       step_pulse_q, step_pulse_d;
  logic       step_req;
  logic [7:0] lfsr_next;
  logic [7:0] load_eff;

  assign step_req  = manual_step | auto_step;
  assign lfsr_next = {q_q[4] ^ q_q[3] ^ q_q[2] ^ q_q[0], q_q[7:1]};
  assign load_eff  = (load_val == 8'h00) ? SEED : load_val;

  always_comb begin
    q_d          = q_q;
    step_pulse_d = 1'b0;
    if (load) begin
      q_d = load_eff;
    end else if (step_req) begin
      q_d          = lfsr_next;
      step_pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q          <= SEED;
      step_pulse_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      step_pulse_q <= step_pulse_d;
    end
  end

`ifdef LFSR_WRAP_DETECT_EN
  // start_q remembers where the current sequence began so a full cycle can be flagged
  logic [7:0] start_q, start_d;
  logic       wrap_pulse_q, wrap_pulse_d;

  always_comb begin
    start_d      = start_q;
    wrap_pulse_d = 1'b0;
    if (load) begin
      start_d = load_eff;
    end else if (step_req) begin
      wrap_pulse_d = (lfsr_next == start_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q      <= SEED;
      wrap_pulse_q <= 1'b0;
    end else begin
      start_q      <= start_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign wrap_pulse = wrap_pulse_q;
`endif

  assign q          = q_q;
  assign nib_lo     = q_q[3:0];
  assign nib_hi     = q_q[7:4];
  assign step_pulse = step_pulse_q;

endmodule
